// File: rtl/mult_pkg.sv
// Shared types and sizing for the 8-bit add/shift multiplier sequencer.
// Holds the state encoding and the operand/iteration parameters.
package mult_pkg;

  localparam int WIDTH = 8;
  localparam int ITER  = 8;
  localparam int CNT_W = $clog2(ITER);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(ITER - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    CAPT  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: grant is combinational from req, the pointer moves on update.
// A lone request always wins; on a tie the requester not served last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // last_q = index of the requester served most recently
  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (req == 2'b01) begin
      gnt = 2'b01;
    end else if (req == 2'b10) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
    if (update && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one add/shift signed multiplier datapath; Done 19 cycles after the request is sampled.
// No grants while Busy; a held request is served at the next IDLE, including the Done cycle.
module mult_arbiter
  import mult_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Req0,
  input  logic               Req1,
  input  logic [WIDTH-1:0]   S0,
  input  logic [WIDTH-1:0]   B0,
  input  logic [WIDTH-1:0]   S1,
  input  logic [WIDTH-1:0]   B1,
  output logic               Gnt0,
  output logic               Gnt1,
  output logic               Done0,
  output logic               Done1,
  output logic [2*WIDTH-1:0] Result,
  output logic               Busy,
  output logic [WIDTH-1:0]   Din_S,
  output logic [WIDTH-1:0]   Din_B,
  output logic               Clr_ld,
  output logic               Add,
  output logic               Sub,
  output logic               Shift,
  input  logic               M,
  input  logic [WIDTH-1:0]   Aval,
  input  logic [WIDTH-1:0]   Bval
);

  state_t               state_q, state_d;
  cnt_t                 cnt_q, cnt_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]     op_s_q, op_s_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;

  logic [1:0]           arb_gnt;
  logic                 arb_update;
  logic                 clr_ld, add, sub, shift;

  rr_arb2 u_rr_arb2 (
    .clk    (Clk),
    .rst_n  (Reset),
    .req    ({Req1, Req0}),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    result_d   = result_q;
    op_s_d     = op_s_q;
    op_b_d     = op_b_q;
    arb_update = 1'b0;
    clr_ld     = 1'b0;
    add        = 1'b0;
    sub        = 1'b0;
    shift      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          arb_update = 1'b1;
          gnt_d      = arb_gnt;
          op_s_d     = arb_gnt[1] ? S1 : S0;
          op_b_d     = arb_gnt[1] ? B1 : B0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        clr_ld  = 1'b1;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        // The multiplier MSB carries negative weight, so the last step subtracts.
        if (cnt_q == CNT_LAST) begin
          sub = M;
        end else begin
          add = M;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = CAPT;
        end else begin
          cnt_d   = cnt_q + cnt_t'(1);
          state_d = ADD;
        end
      end
      CAPT: begin
        result_d = {Aval, Bval};
        done_d   = gnt_q;
        gnt_d    = 2'b00;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      result_q <= '0;
      op_s_q   <= '0;
      op_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      op_s_q   <= op_s_d;
      op_b_q   <= op_b_d;
    end
  end

  assign Gnt0   = gnt_q[0];
  assign Gnt1   = gnt_q[1];
  assign Done0  = done_q[0];
  assign Done1  = done_q[1];
  assign Result = result_q;
  assign Busy   = (state_q != IDLE);
  assign Din_S  = op_s_q;
  assign Din_B  = op_b_q;
  assign Clr_ld = clr_ld;
  assign Add    = add;
  assign Sub    = sub;
  assign Shift  = shift;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter paired with a behavioural add/shift datapath; a cycle-level model is compared every cycle.
module tb_mult_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [7:0]  S0 = '0, B0 = '0, S1 = '0, B1 = '0;
  logic        Gnt0, Gnt1, Done0, Done1, Busy;
  logic [15:0] Result;
  logic [7:0]  Din_S, Din_B;
  logic        Clr_ld, Add, Sub, Shift;
  logic        M;
  logic [7:0]  Aval, Bval;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 Clk = ~Clk;

  mult_arbiter dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1),
    .S0(S0), .B0(B0), .S1(S1), .B1(B1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Result(Result), .Busy(Busy), .Din_S(Din_S), .Din_B(Din_B),
    .Clr_ld(Clr_ld), .Add(Add), .Sub(Sub), .Shift(Shift),
    .M(M), .Aval(Aval), .Bval(Bval)
  );

  // Datapath: A/X accumulator, B multiplier, S multiplicand, 9-bit adder.
  logic [7:0] dp_a, dp_b, dp_s;
  logic       dp_x;
  always @(posedge Clk) begin
    if (!Reset) begin
      dp_a <= '0; dp_b <= '0; dp_s <= '0; dp_x <= 1'b0;
    end else if (Clr_ld) begin
      dp_a <= '0; dp_x <= 1'b0; dp_b <= Din_B; dp_s <= Din_S;
    end else if (Add) begin
      {dp_x, dp_a} <= {dp_a[7], dp_a} + {dp_s[7], dp_s};
    end else if (Sub) begin
      {dp_x, dp_a} <= {dp_a[7], dp_a} - {dp_s[7], dp_s};
    end else if (Shift) begin
      dp_a <= {dp_x, dp_a[7:1]};
      dp_b <= {dp_a[0], dp_b[7:1]};
    end
  end
  assign M    = dp_b[0];
  assign Aval = dp_a;
  assign Bval = dp_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Model: phase = cycles since the grant edge (0 = idle, 1 = LOAD ... 18 = CAPT).
  int          m_phase, m_last, m_win;
  logic [1:0]  m_gnt, m_done;
  logic [7:0]  m_s, m_b;
  logic [15:0] m_prod, m_result;

  always @(posedge Clk) begin
    cyc++;
    if (!Reset) begin
      m_phase = 0; m_last = 1; m_gnt = 2'b00; m_done = 2'b00;
      m_result = '0; m_s = '0; m_b = '0; m_prod = '0;
    end else begin
      m_done = 2'b00;
      if (m_phase == 18) begin
        m_result = m_prod; m_done = m_gnt; m_gnt = 2'b00; m_phase = 0;
      end else if (m_phase > 0) begin
        m_phase++;
      end else if (Req0 || Req1) begin
        if (Req0 && Req1) m_win = (m_last == 1) ? 0 : 1;
        else              m_win = Req1 ? 1 : 0;
        m_last  = m_win;
        m_s     = m_win ? S1 : S0;
        m_b     = m_win ? B1 : B0;
        m_prod  = smul(m_s, m_b);
        m_gnt   = m_win ? 2'b10 : 2'b01;
        m_phase = 1;
      end
    end
  end

  int          done_cyc_q[$];
  int          done_who_q[$];
  logic [15:0] done_res_q[$];
  int          cnt_shift, cnt_clr;
  bit          add_ph, shift_ph;

  always @(negedge Clk) begin
    if (cyc > 0) begin
      chk("busy",   Busy,   m_phase != 0);
      chk("gnt0",   Gnt0,   m_gnt[0]);
      chk("gnt1",   Gnt1,   m_gnt[1]);
      chk("done0",  Done0,  m_done[0]);
      chk("done1",  Done1,  m_done[1]);
      chk("result", Result, m_result);
      add_ph   = (m_phase >= 2) && (m_phase <= 16) && (m_phase % 2 == 0);
      shift_ph = (m_phase >= 3) && (m_phase <= 17) && (m_phase % 2 == 1);
      chk("cmd_excl", ($countones({Clr_ld, Add, Sub, Shift}) <= 1), 1);
      chk("clr_ld", Clr_ld, m_phase == 1);
      chk("shift",  Shift,  shift_ph);
      chk("add",    Add,    add_ph && (m_phase != 16) && M);
      chk("sub",    Sub,    add_ph && (m_phase == 16) && M);
      if (m_phase == 1) begin
        chk("din_s", Din_S, m_s);
        chk("din_b", Din_B, m_b);
        cnt_shift = 0;
        cnt_clr   = 0;
      end
      if (Shift)  cnt_shift++;
      if (Clr_ld) cnt_clr++;
      if (Done0 || Done1) begin
        chk("shift_count", cnt_shift, 8);
        chk("clr_count",   cnt_clr,   1);
        done_cyc_q.push_back(cyc);
        done_who_q.push_back(Done1 ? 1 : 0);
        done_res_q.push_back(Result);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_dones(input string nm, input int target, input int budget);
    int n;
    n = 0;
    while (done_cyc_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    if (done_cyc_q.size() < target) chk({nm, "_timeout"}, done_cyc_q.size(), target);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_ctl"},    {Gnt0, Gnt1, Done0, Done1, Busy, Clr_ld, Add, Sub, Shift}, 0);
    chk({nm, "_result"}, Result, 0);
    chk({nm, "_din_s"},  Din_S, 0);
    chk({nm, "_din_b"},  Din_B, 0);
  endtask

  task automatic run_op(input string nm, input bit who, input logic [7:0] s, input logic [7:0] b,
                        input logic [15:0] exp, input bit chg);
    int t0, n0;
    if (who) begin Req1 = 1'b1; S1 = s; B1 = b; end
    else     begin Req0 = 1'b1; S0 = s; B0 = b; end
    t0 = cyc;
    n0 = done_cyc_q.size();
    tick();
    chk({nm, "_gnt_c1"}, who ? Gnt1 : Gnt0, 1);
    Req0 = 1'b0; Req1 = 1'b0;
    if (chg) begin
      tick();
      S0 = ~S0; B0 = B0 + 8'd77; S1 = ~S1; B1 = 8'h80;
    end
    wait_dones(nm, n0 + 1, 40);
    if (done_cyc_q.size() > n0) begin
      chk({nm, "_res"},      done_res_q[n0], exp);
      chk({nm, "_who"},      done_who_q[n0], who);
      chk({nm, "_done_cyc"}, done_cyc_q[n0] - t0, 19);
    end
  endtask

  initial begin
    int t0, t1, n0;
    Reset = 1'b0;
    repeat (3) tick();
    chk_outs_zero("reset");
    Reset = 1'b1;
    tick();

    run_op("r0_7x5",    1'b0, 8'h07, 8'h05, 16'h0023, 1'b0);
    run_op("r1_fex3",   1'b1, 8'hFE, 8'h03, 16'hFFFA, 1'b0);
    run_op("r1_3xfe",   1'b1, 8'h03, 8'hFE, 16'hFFFA, 1'b0);
    run_op("r1_ffxff",  1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
    run_op("r0_opchg",  1'b0, 8'h12, 8'h34, 16'h03A8, 1'b1);
    run_op("r1_80x80",  1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);

    // Abort in cycle 9; the held request restarts and completes.
    Req0 = 1'b1; S0 = 8'h85; B0 = 8'h0B;
    t0 = cyc;
    n0 = done_cyc_q.size();
    while (cyc < t0 + 9) tick();
    Reset = 1'b0;
    tick();
    chk_outs_zero("abort");
    Reset = 1'b1;
    t1 = cyc;
    tick();
    Req0 = 1'b0;
    wait_dones("abort", n0 + 1, 40);
    chk("abort_one_done", done_cyc_q.size(), n0 + 1);
    if (done_cyc_q.size() > n0) begin
      chk("abort_res",      done_res_q[n0], 16'hFAB7);
      chk("abort_done_cyc", done_cyc_q[n0] - t1, 19);
    end

    // Simultaneous held requests from reset alternate with a 19-cycle period.
    Reset = 1'b0;
    tick();
    tick();
    S0 = 8'h07; B0 = 8'h05; S1 = 8'hFE; B1 = 8'h03;
    Reset = 1'b1; Req0 = 1'b1; Req1 = 1'b1;
    t0 = cyc;
    n0 = done_cyc_q.size();
    wait_dones("tie", n0 + 4, 100);
    Req0 = 1'b0; Req1 = 1'b0;
    if (done_cyc_q.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("tie_who", done_who_q[n0 + i], i % 2);
        chk("tie_cyc", done_cyc_q[n0 + i] - t0, 19 * (i + 1));
        chk("tie_res", done_res_q[n0 + i], (i % 2) ? 16'hFFFA : 16'h0023);
      end
    end
    wait_dones("tie_tail", n0 + 5, 30);
    repeat (3) tick();
    chk("final_idle", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
